// File: rtl/pe_mac9.sv
// pe_mac9: 3x3 conv PE, 9 signed int8 MACs + bias, arithmetic shift, clip/activate to int8
//   Ports: clk, reset (async active-low), in/weight (9 packed int8, tap0 in MSB byte),
//   bias (signed), bound_level (clip mode), step (shift 0..7), en -> out (int8), out_en.
//   Two-stage pipeline: products captured on the en edge, result one edge later.
//   Build option PE_ROUND_EN: round half up before the shift (default: floor shift).
module pe_mac9 #(
    parameter int DATA_W = 8,
    parameter int N      = 9,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N*DATA_W-1:0] in,
    input  logic [N*DATA_W-1:0] weight,
    input  logic [BIAS_W-1:0]   bias,
    input  logic [1:0]          bound_level,
    input  logic [2:0]          step,
    input  logic                en,
    output logic [DATA_W-1:0]   out,
    output logic                out_en
);
    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_r [N];
    logic signed [BIAS_W-1:0] bias_r;
    logic [1:0]               mode_r;
    logic [2:0]               step_r;
    logic                     v_r;

    logic signed [ACC_W-1:0]  acc, sh, lo, hi;
    logic [DATA_W-1:0]        clip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) prod_r[i] <= '0;
            bias_r <= '0;
            mode_r <= '0;
            step_r <= '0;
            v_r    <= 1'b0;
        end else begin
            v_r <= en;
            if (en) begin
                for (int i = 0; i < N; i++)
                    prod_r[i] <= $signed(in[(N-1-i)*DATA_W +: DATA_W]) * $signed(weight[(N-1-i)*DATA_W +: DATA_W]);
                bias_r <= $signed(bias);
                mode_r <= bound_level;
                step_r <= step;
            end
        end
    end

    // Accumulator is wide enough for nine full-scale products plus bias, so the sum is exact
    // and saturation below compares the true value.
    always_comb begin
        acc = ACC_W'(bias_r);
        for (int i = 0; i < N; i++) acc = acc + ACC_W'(prod_r[i]);
`ifdef PE_ROUND_EN
        acc = acc + ((step_r != 3'd0) ? (ACC_W'(1) <<< (step_r - 3'd1)) : ACC_W'(0));
`endif
        sh   = acc >>> step_r;
        lo   = (mode_r == 2'b01) ? ACC_W'(-128) : ACC_W'(0);
        hi   = mode_r[1] ? ACC_W'(63) : ACC_W'(127);
        clip = (mode_r == 2'b11) ? sh[DATA_W-1:0] :
               (sh < lo)         ? lo[DATA_W-1:0] :
               (sh > hi)         ? hi[DATA_W-1:0] : sh[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out    <= '0;
            out_en <= 1'b0;
        end else begin
            out_en <= v_r;
            if (v_r) out <= clip;
        end
    end
endmodule

// File: tb/tb_pe_mac9.sv
// tb_pe_mac9: self-checking bench for pe_mac9 (directed table, random stream, reset cases)
module tb_pe_mac9;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] in = '0;
    logic [71:0] weight = '0;
    logic [15:0] bias = '0;
    logic [1:0]  bound_level = '0;
    logic [2:0]  step = '0;
    logic        en = 1'b0;
    logic [7:0]  out;
    logic        out_en;

    int errors = 0;
    int checks = 0;
    logic [7:0] last_exp = 8'h00;

    pe_mac9 dut (
        .clk(clk), .reset(reset), .in(in), .weight(weight), .bias(bias),
        .bound_level(bound_level), .step(step), .en(en), .out(out), .out_en(out_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] a;
        logic [71:0] w;
        logic [15:0] b;
        logic [1:0]  m;
        logic [2:0]  s;
        logic [7:0]  e;
        string       nm;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    // Reference: exact integer sum, floor division by 2^step, then clip by mode.
    function automatic logic [7:0] model(input logic [71:0] a, input logic [71:0] w,
                                         input logic [15:0] b, input logic [1:0] m, input logic [2:0] s);
        longint acc, d, q;
        acc = longint'($signed(b));
        for (int i = 0; i < 9; i++)
            acc += longint'($signed(a[8*i +: 8])) * longint'($signed(w[8*i +: 8]));
        d = longint'(1) << s;
`ifdef PE_ROUND_EN
        if (s != 3'd0) acc += d / 2;
`endif
        q = (acc >= 0) ? acc / d : -((-acc + d - 1) / d);
        case (m)
            2'b00:   q = (q < 0) ? 0 : (q > 127) ? 127 : q;
            2'b01:   q = (q < -128) ? -128 : (q > 127) ? 127 : q;
            2'b10:   q = (q < 0) ? 0 : (q > 63) ? 63 : q;
            default: q = q & 255;
        endcase
        return q[7:0];
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        in = v.a; weight = v.w; bias = v.b; bound_level = v.m; step = v.s; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk({v.nm, "_lat_en"}, {7'b0, out_en}, 8'h00);
        chk({v.nm, "_lat_out"}, out, last_exp);
        @(negedge clk);
        chk({v.nm, "_en"}, {7'b0, out_en}, 8'h01);
        chk(v.nm, out, v.e);
        last_exp = v.e;
    endtask

    logic       de [70];
    logic [7:0] dx [70];

    initial begin
        vt[0]  = '{{9{8'h01}}, {9{8'h01}}, 16'h0000, 2'b00, 3'd0, 8'h09, "ones"};
        vt[1]  = '{{9{8'h0A}}, {9{8'h14}}, 16'h0000, 2'b00, 3'd0, 8'h7F, "sat127"};
        vt[2]  = '{{9{8'h0A}}, {9{8'h14}}, 16'h0000, 2'b11, 3'd0, 8'h08, "wrap"};
        vt[3]  = '{{9{8'h01}}, {9{8'hFF}}, 16'h0000, 2'b00, 3'd0, 8'h00, "relu_neg"};
        vt[4]  = '{{9{8'h01}}, {9{8'hFF}}, 16'h0000, 2'b01, 3'd0, 8'hF7, "sat_neg"};
        vt[5]  = '{{8'd10, 64'd0}, {8'd10, 64'd0}, 16'h0004, 2'b01, 3'd3, 8'h0D, "bias_shift"};
`ifdef PE_ROUND_EN
        vt[6]  = '{{8'd10, 64'd0}, {8'd10, 64'd0}, 16'h0000, 2'b01, 3'd3, 8'h0D, "shift3"};
        vt[8]  = '{{9{8'h01}}, {9{8'hFF}}, 16'h0000, 2'b01, 3'd1, 8'hFC, "neg_shift"};
`else
        vt[6]  = '{{8'd10, 64'd0}, {8'd10, 64'd0}, 16'h0000, 2'b01, 3'd3, 8'h0C, "shift3"};
        vt[8]  = '{{9{8'h01}}, {9{8'hFF}}, 16'h0000, 2'b01, 3'd1, 8'hFB, "neg_shift"};
`endif
        vt[7]  = '{{9{8'h0A}}, {9{8'h14}}, 16'h0000, 2'b10, 3'd0, 8'h3F, "relu63"};
        vt[9]  = '{{9{8'h80}}, {9{8'h7F}}, 16'h0000, 2'b01, 3'd7, 8'h80, "sat_min"};
        vt[10] = '{{9{8'h80}}, {9{8'h80}}, 16'h7FFF, 2'b11, 3'd0, 8'hFF, "max_wrap"};
        vt[11] = '{{9{8'h80}}, {9{8'h80}}, 16'h7FFF, 2'b01, 3'd0, 8'h7F, "max_sat"};
        vt[12] = '{{9{8'h0A}}, {9{8'h14}}, 16'h0000, 2'b10, 3'd5, 8'h38, "relu63_shift"};

        repeat (2) @(negedge clk);
        chk("rst_out", out, 8'h00);
        chk("rst_en", {7'b0, out_en}, 8'h00);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        @(negedge clk);
        chk("hold_en", {7'b0, out_en}, 8'h00);
        chk("hold_out", out, last_exp);

        // Random stream: 64 windows with one en=0 gap; result checked two negedges after drive.
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("rnd_en", {7'b0, out_en}, {7'b0, de[c-2]});
                chk("rnd_out", out, dx[c-2]);
            end
            if (c < 65) begin
                en = (c != 32);
                in = rnd72(); weight = rnd72(); bias = 16'($urandom());
                bound_level = 2'($urandom_range(3)); step = 3'($urandom_range(7));
                if (en) last_exp = model(in, weight, bias, bound_level, step);
            end else en = 1'b0;
            de[c] = en;
            dx[c] = last_exp;
        end

        // Reset mid-stream, between clock edges.
        @(negedge clk);
        in = {9{8'h05}}; weight = {9{8'h05}}; bias = '0; bound_level = 2'b00; step = 3'd0; en = 1'b1;
        @(negedge clk);
        in = {9{8'h03}};
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_out", out, 8'h00);
        chk("midrst_en", {7'b0, out_en}, 8'h00);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_exp = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("postrst_en", {7'b0, out_en}, 8'h00);
            chk("postrst_out", out, 8'h00);
        end
        run_vec(vt[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
